// File: rtl/lcd_panel_model.sv
// Behavioural HD44780-style character panel: 128-byte DDRAM, address counter, busy timing, host read-back.
// Define LCD_NIBBLE_EN to use a 4-bit bus (data on lcd_db_in[7:4], high nibble first).
module lcd_panel_model #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] addr_cnt,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic       err_busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);
  // The fill itself spends 128 busy cycles; the tail covers the rest.
  localparam logic [15:0] TAIL_LOAD  = 16'(CLEAR_CYCLES - 129);

  state_t      state;
  logic        e_q;
  logic        inc_dir;
  logic [15:0] cnt;
  logic [6:0]  fill_addr;
  logic [7:0]  mem [128];

  logic        fall;
  logic        wr_ev;
  logic        rd_step;
  logic        exec;
  logic [7:0]  wr_data;
  logic [7:0]  rd_val;
  logic [7:0]  rd_bus;
  logic        mem_we;
  logic [6:0]  mem_wa;
  logic [7:0]  mem_wd;

  assign fall = e_q & ~lcd_e;

`ifdef LCD_NIBBLE_EN
  // phase=0 expects the high nibble, phase=1 the low nibble; shared by reads and writes.
  logic       phase;
  logic [3:0] hi_nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= 1'b0;
      hi_nib <= 4'h0;
    end else if (fall) begin
      phase <= ~phase;
      if (!phase) hi_nib <= lcd_db_in[7:4];
    end
  end

  assign wr_ev   = fall & ~lcd_rw & phase;
  assign rd_step = fall & lcd_rw & lcd_rs & phase;
  assign wr_data = {hi_nib, lcd_db_in[7:4]};
  assign rd_bus  = phase ? {rd_val[3:0], 4'h0} : {rd_val[7:4], 4'h0};
`else
  assign wr_ev   = fall & ~lcd_rw;
  assign rd_step = fall & lcd_rw & lcd_rs;
  assign wr_data = lcd_db_in;
  assign rd_bus  = rd_val;
`endif

  assign exec      = wr_ev & (state == IDLE);
  assign rd_val    = lcd_rs ? mem[addr_cnt] : {busy, addr_cnt};
  assign dbg_char  = mem[dbg_addr];
  assign dbg_state = state;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = fill_addr;
    mem_wd = 8'h20;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (exec && lcd_rs) begin
        mem_we = 1'b1;
        mem_wa = addr_cnt;
        mem_wd = wr_data;
      end
    end
  end

  // DDRAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cnt        <= 16'd0;
      fill_addr  <= 7'd0;
      addr_cnt   <= 7'd0;
      inc_dir    <= 1'b1;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      err_busy   <= 1'b0;
      lcd_db_oe  <= 1'b0;
      lcd_db_out <= 8'h00;
      e_q        <= 1'b0;
    end else begin
      e_q        <= lcd_e;
      err_busy   <= wr_ev & (state != IDLE);
      lcd_db_oe  <= lcd_rw & lcd_e;
      lcd_db_out <= (lcd_rw & lcd_e) ? rd_bus : 8'h00;

      if (rd_step) addr_cnt <= inc_dir ? addr_cnt + 7'd1 : addr_cnt - 7'd1;

      case (state)
        IDLE: begin
          if (exec) begin
            state <= BUSY;
            busy  <= 1'b1;
            cnt   <= BUSY_LOAD;
            if (lcd_rs) begin
              addr_cnt <= inc_dir ? addr_cnt + 7'd1 : addr_cnt - 7'd1;
            end else begin
              casez (wr_data)
                8'b1???????: addr_cnt <= wr_data[6:0];
                8'b0001????: begin
                  if (!wr_data[3]) addr_cnt <= wr_data[2] ? addr_cnt + 7'd1 : addr_cnt - 7'd1;
                end
                8'b00001???: begin
                  disp_on   <= wr_data[2];
                  cursor_on <= wr_data[1];
                  blink_on  <= wr_data[0];
                end
                8'b000001??: inc_dir <= wr_data[1];
                8'b0000001?: begin
                  addr_cnt <= 7'd0;
                  cnt      <= CLEAR_LOAD;
                end
                8'b00000001: begin
                  addr_cnt  <= 7'd0;
                  inc_dir   <= 1'b1;
                  fill_addr <= 7'd0;
                  state     <= CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        CLEAR: begin
          fill_addr <= fill_addr + 7'd1;
          if (fill_addr == 7'd127) begin
            state <= BUSY;
            cnt   <= TAIL_LOAD;
          end
        end
        BUSY: begin
          if (cnt == 16'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_panel_model.sv
// Directed bench for lcd_panel_model: expected values queued at stimulus time, popped and asserted on DUT response.
// Handshake: a transfer is one lcd_e pulse; the panel acts on its falling edge, read data is valid while lcd_db_oe=1.
module tb_lcd_panel_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db_in;
  logic [7:0] lcd_db_out;
  logic       lcd_db_oe;
  logic       busy;
  logic       disp_on;
  logic       cursor_on;
  logic       blink_on;
  logic [6:0] addr_cnt;
  logic [6:0] dbg_addr;
  logic [7:0] dbg_char;
  logic       err_busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  lcd_panel_model dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db_in(lcd_db_in), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
    .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .addr_cnt(addr_cnt), .dbg_addr(dbg_addr), .dbg_char(dbg_char),
    .err_busy(err_busy), .dbg_state(dbg_state)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  rd_out;
  logic        rd_oe;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_obs(input logic [15:0] obs);
    logic [15:0] ev;
    string       tg;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow observed=%0h expected=none", obs);
    end else begin
      ev = exp_q.pop_front();
      tg = tag_q.pop_front();
      assert (obs === ev) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tg, obs, ev);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] ev);
    push_exp(tag, ev);
    check_obs(obs);
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    lcd_rs    = rs;
    lcd_rw    = rw;
    lcd_db_in = d;
    lcd_e     = 1'b1;
    step();
    rd_out = lcd_db_out;
    rd_oe  = lcd_db_oe;
    lcd_e  = 1'b0;
    step();
    lcd_rw = 1'b0;
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
`ifdef LCD_NIBBLE_EN
    strobe(rs, 1'b0, {d[7:4], 4'h0});
    strobe(rs, 1'b0, {d[3:0], 4'h0});
`else
    strobe(rs, 1'b0, d);
`endif
  endtask

  task automatic rd(input logic rs, output logic [7:0] v, output logic oe);
`ifdef LCD_NIBBLE_EN
    strobe(rs, 1'b1, 8'h00);
    v[7:4] = rd_out[7:4];
    oe     = rd_oe;
    strobe(rs, 1'b1, 8'h00);
    v[3:0] = rd_out[7:4];
`else
    strobe(rs, 1'b1, 8'h00);
    v  = rd_out;
    oe = rd_oe;
`endif
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      step();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    measure_busy(n);
    chk(tag, {15'd0, busy}, 16'd0);
  endtask

  task automatic peek(input logic [6:0] a, output logic [7:0] v);
    dbg_addr = a;
    #1;
    v = dbg_char;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int         n;
    int         bad;
    logic [7:0] v;
    logic       oe;

    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_db_in = 8'h00; dbg_addr = 7'd0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy",  {15'd0, busy}, 16'd0);
    chk("rst_ac",    {9'd0, addr_cnt}, 16'd0);
    chk("rst_ctrl",  {13'd0, disp_on, cursor_on, blink_on}, 16'd0);
    chk("rst_err",   {15'd0, err_busy}, 16'd0);
    chk("rst_bus",   {7'd0, lcd_db_oe, lcd_db_out}, 16'd0);
    chk("rst_state", {14'd0, dbg_state}, 16'd0);

    // Clear: busy for the full clear time, every cell blank, AC home.
    push_exp("clear_busy_cycles", 16'd1640);
    wr(1'b0, 8'h01);
    measure_busy(n);
    check_obs(16'(n));
    chk("clear_ac", {9'd0, addr_cnt}, 16'd0);
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      peek(7'(a), v);
      if (v !== 8'h20) bad++;
    end
    chk("clear_fill_bad_cells", 16'(bad), 16'd0);

    // Set address then data write.
    wr(1'b0, 8'h85);
    wait_idle("idle_after_setaddr");
    push_exp("data_busy_cycles", 16'd40);
    wr(1'b1, 8'h2E);
    measure_busy(n);
    check_obs(16'(n));
    peek(7'd5, v);
    chk("ddram5", {8'd0, v}, 16'h002E);
    chk("ac_after_data", {9'd0, addr_cnt}, 16'd6);

    // Decrement mode with wrap below zero.
    wr(1'b0, 8'h04);
    wait_idle("idle_after_entry");
    wr(1'b0, 8'h80);
    wait_idle("idle_after_ac0");
    wr(1'b1, 8'h41);
    wait_idle("idle_after_wrap_write");
    peek(7'd0, v);
    chk("ddram0", {8'd0, v}, 16'h0041);
    chk("ac_wrap", {9'd0, addr_cnt}, 16'd127);

    // Write while busy is dropped and flagged; reads still work.
    wr(1'b1, 8'h55);
    repeat (8) step();
    wr(1'b1, 8'h77);
    chk("err_pulse", {15'd0, err_busy}, 16'd1);
    step();
    chk("err_one_cycle", {15'd0, err_busy}, 16'd0);
    peek(7'd126, v);
    chk("discard_mem", {8'd0, v}, 16'h0020);
    chk("discard_ac", {9'd0, addr_cnt}, 16'd126);
    rd(1'b0, v, oe);
    chk("busy_read_val", {8'd0, v}, 16'h00FE);
    chk("busy_read_oe", {15'd0, oe}, 16'd1);
    chk("read_no_err", {15'd0, err_busy}, 16'd0);
    chk("bus_idle_after_read", {7'd0, lcd_db_oe, lcd_db_out}, 16'd0);
    wait_idle("idle_after_discard");
    peek(7'd127, v);
    chk("ddram127", {8'd0, v}, 16'h0055);

    // Data read in increment mode steps AC and does not set busy.
    wr(1'b0, 8'h06);
    wait_idle("idle_after_entry_inc");
    wr(1'b0, 8'h85);
    wait_idle("idle_after_setaddr5");
    rd(1'b1, v, oe);
    chk("data_read_val", {8'd0, v}, 16'h002E);
    chk("data_read_ac", {9'd0, addr_cnt}, 16'd6);
    chk("data_read_busy", {15'd0, busy}, 16'd0);

    // Display control and cursor shifts.
    wr(1'b0, 8'h0F);
    chk("ctrl_all_on", {13'd0, disp_on, cursor_on, blink_on}, 16'd7);
    wait_idle("idle_after_ctrl");
    wr(1'b0, 8'h14);
    wait_idle("idle_after_shift_r");
    chk("shift_right", {9'd0, addr_cnt}, 16'd7);
    wr(1'b0, 8'h1C);
    wait_idle("idle_after_disp_shift");
    chk("display_shift_ac", {9'd0, addr_cnt}, 16'd7);
    wr(1'b0, 8'h10);
    wait_idle("idle_after_shift_l");
    chk("shift_left", {9'd0, addr_cnt}, 16'd6);
    wr(1'b0, 8'h0C);
    chk("ctrl_disp_only", {13'd0, disp_on, cursor_on, blink_on}, 16'd4);
    wait_idle("idle_after_ctrl2");

    // Home keeps DDRAM, busy for the clear time.
    push_exp("home_busy_cycles", 16'd1640);
    wr(1'b0, 8'h02);
    measure_busy(n);
    check_obs(16'(n));
    chk("home_ac", {9'd0, addr_cnt}, 16'd0);
    peek(7'd5, v);
    chk("home_keeps_ddram", {8'd0, v}, 16'h002E);

    // Reset in the middle of a clear fill.
    wr(1'b0, 8'h01);
    repeat (50) step();
    pulse_rst();
    chk("midclear_busy", {15'd0, busy}, 16'd0);
    chk("midclear_state", {14'd0, dbg_state}, 16'd0);
    chk("midclear_ctrl", {13'd0, disp_on, cursor_on, blink_on}, 16'd0);
    peek(7'd0, v);
    chk("midclear_filled", {8'd0, v}, 16'h0020);
    peek(7'd127, v);
    chk("midclear_untouched", {8'd0, v}, 16'h0055);

`ifdef LCD_NIBBLE_EN
    strobe(1'b0, 1'b0, 8'h80);
    strobe(1'b0, 1'b0, 8'hA0);
    chk("nibble_ac", {9'd0, addr_cnt}, 16'h000A);
    wait_idle("idle_after_nibble");
    strobe(1'b0, 1'b0, 8'h80);
    pulse_rst();
    wr(1'b0, 8'h85);
    chk("nibble_phase_rst", {9'd0, addr_cnt}, 16'd5);
    wait_idle("idle_after_nibble2");
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_panel_model.md
LCD_PANEL_MODEL -- requirements
Module: lcd_panel_model

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40, clk cycles busy after a non-clear instruction or data write.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1640, clk cycles busy after clear or return-home; legal values are 130 or more.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port lcd_e, input, 1, panel enable strobe.
REQ-006 SHALL have port lcd_rs, input, 1; 0 = instruction, 1 = data.
REQ-007 SHALL have port lcd_rw, input, 1; 0 = write, 1 = read.
REQ-008 SHALL have port lcd_db_in, input, 8, bus from host.
REQ-009 SHALL have port lcd_db_out, output, 8, read data.
REQ-010 SHALL have port lcd_db_oe, output, 1, high while lcd_db_out is valid.
REQ-011 SHALL have port busy, output, 1, panel busy flag.
REQ-012 SHALL have port disp_on / cursor_on / blink_on, output, 1 each, display-control state.
REQ-013 SHALL have port addr_cnt, output, 7, address counter (AC).
REQ-014 SHALL have port dbg_addr, input, 7, DDRAM peek address.
REQ-015 SHALL have port dbg_char, output, 8, DDRAM[dbg_addr], combinational.
REQ-016 SHALL have port err_busy, output, 1, one-cycle pulse when a write arrives while busy.

Function
REQ-017 SHALL register lcd_e every cycle; transfer event = registered lcd_e high AND lcd_e low (falling edge). lcd_rs, lcd_rw and lcd_db_in are sampled in that cycle.
REQ-018 SHALL hold a 128x8 DDRAM and a 7-bit AC that wraps modulo 128 in both directions.
REQ-019 SHALL use FSM states IDLE, CLEAR and BUSY. busy is 1 in CLEAR and BUSY. A write event in IDLE executes; a write event in CLEAR or BUSY is discarded and pulses err_busy.
REQ-020 SHALL handle instruction 0x01 (clear): AC=0, I/D=1, enter CLEAR, write 0x20 to one address per cycle from 0 to 127, then go to BUSY for the remaining CLEAR_CYCLES-128 cycles.
REQ-021 SHALL handle instructions 0x02/0x03 (home): AC=0, enter BUSY for CLEAR_CYCLES; DDRAM unchanged.
REQ-022 SHALL handle instructions 0x04-0x07 (entry mode): I/D = bit1; bit0 (shift) ignored.
REQ-023 SHALL handle instructions 0x08-0x0F: disp_on = bit2, cursor_on = bit1, blink_on = bit0.
REQ-024 SHALL handle instructions 0x10-0x1F: if bit3=0, AC+1 when bit2=1, else AC-1; if bit3=1, AC is unchanged.
REQ-025 SHALL accept instructions 0x20-0x7F (function set, CGRAM address) with no state change other than busy.
REQ-026 SHALL handle instructions 0x80-0xFF: AC = data[6:0].
REQ-027 SHALL handle data write: DDRAM[AC] = data, then AC+1 if I/D=1 else AC-1.
REQ-028 SHALL, for every executed write except clear/home, enter BUSY for exactly BUSY_CYCLES cycles, counted from the cycle after the event, then return to IDLE.
REQ-029 SHALL, while lcd_rw=1 and lcd_e=1, drive lcd_db_oe=1 with lcd_db_out = {busy, AC} when rs=0, or DDRAM[AC] when rs=1. Otherwise lcd_db_oe=0 and lcd_db_out=0.
REQ-030 SHALL, on a data-read falling edge, step AC by I/D. Reads are honoured while busy and do not pulse err_busy.
REQ-031 SHALL, on a clear-fill write and a host write in the same cycle, discard the host write per REQ-019.

Reset
REQ-032 SHALL, on rst, set: state IDLE, busy=0, AC=0, I/D=1, disp_on/cursor_on/blink_on=0, err_busy=0, lcd_db_oe=0, lcd_db_out=0, registered lcd_e=0.
REQ-033 SHALL abort any clear fill or busy count on rst. DDRAM contents are not reset and stay as left.
REQ-034 SHALL ignore any falling edge in the cycle rst is high.

Configuration
REQ-035 SHALL support macro LCD_NIBBLE_EN.
- Defined: only lcd_db_in[7:4] carries data. The first falling edge latches the high nibble, the second latches the low nibble, and the instruction executes on the second edge.
- Defined, reads: return the high nibble on the first strobe and the low nibble on the second, on lcd_db_out[7:4]; lcd_db_out[3:0]=0. AC steps after the second strobe.
- Defined, reset: the nibble phase resets to high on rst.
- Undefined: 8-bit transfers only and no phase logic.

Verification
REQ-036 SHALL cover: reset, then instruction 0x01 -> busy=1 for exactly 1640 cycles; dbg_char=0x20 at all 128 addresses; AC=0.
REQ-037 SHALL cover: 0x80|0x05 then data 0x2E -> DDRAM[5]=0x2E, AC=6, busy high for 40 cycles.
REQ-038 SHALL cover: 0x04 (decrement), AC=0, data 0x41 -> DDRAM[0]=0x41, AC=127 (wrap).
REQ-039 SHALL cover: data write 10 cycles after a previous write -> err_busy pulse, DDRAM and AC unchanged. Instruction read during busy -> lcd_db_out[7]=1.
REQ-040 SHALL cover: 0x0F -> disp_on, cursor_on, blink_on = 1; rst raised mid-clear -> busy=0 next cycle, FSM IDLE.
REQ-041 SHALL cover, with LCD_NIBBLE_EN defined: nibbles 0x8 then 0xA -> AC=0x0A; a single nibble followed by rst -> next nibble is treated as high.
